// File: rtl/bin2bcd_converter.sv
// Sequential 20-bit binary to 6-digit packed BCD converter (double-dabble, one bit per clock).
// Feeds the seven-segment display driver; bcd_sig only changes on completion or reset.
module bin2bcd_converter (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start_sig,
    input  logic [19:0] bin_data,
    output logic [23:0] bcd_sig,
    output logic        done_sig,
    output logic        busy_sig,
    output logic        ovf_sig
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t      state;
    logic [19:0] shift_reg;
    logic [23:0] acc;
    logic [4:0]  bit_cnt;
    logic        ovf_pend;
    logic [23:0] acc_adj;

    // All six nibbles are adjusted in parallel from their pre-shift values.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 6; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= StIdle;
            shift_reg <= '0;
            acc       <= '0;
            bit_cnt   <= '0;
            ovf_pend  <= 1'b0;
            bcd_sig   <= '0;
            done_sig  <= 1'b0;
            busy_sig  <= 1'b0;
            ovf_sig   <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_sig) begin
                        shift_reg <= bin_data;
                        acc       <= '0;
                        bit_cnt   <= '0;
                        ovf_pend  <= (bin_data > 20'd999_999);
                        busy_sig  <= 1'b1;
                        state     <= StShift;
                    end
                end
                StShift: begin
                    acc       <= {acc_adj[22:0], shift_reg[19]};
                    shift_reg <= {shift_reg[18:0], 1'b0};
                    bit_cnt   <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd19) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    // Overflowed inputs still take the full 20 shifts, so latency is fixed.
                    bcd_sig  <= ovf_pend ? 24'h999_999 : acc;
                    ovf_sig  <= ovf_pend;
                    done_sig <= 1'b1;
                    busy_sig <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: directed steps plus random values
// compared against a divide-by-ten decimal reference model.
module tb_bin2bcd_converter;

    logic        CLK;
    logic        RSTn;
    logic        start_sig;
    logic [19:0] bin_data;
    logic [23:0] bcd_sig;
    logic        done_sig;
    logic        busy_sig;
    logic        ovf_sig;

    int total;
    int bad;

    bin2bcd_converter dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start_sig (start_sig),
        .bin_data  (bin_data),
        .bcd_sig   (bcd_sig),
        .done_sig  (done_sig),
        .busy_sig  (busy_sig),
        .ovf_sig   (ovf_sig)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned t;
        r = '0;
        t = v;
        if (v > 999_999) return 24'h999_999;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full conversion: latency, busy width, single done pulse, result and overflow.
    task automatic convert(input logic [19:0] v, input string tag);
        int lat;
        int busy_n;
        @(negedge CLK);
        start_sig = 1'b1;
        bin_data  = v;
        @(posedge CLK);
        #1;
        start_sig = 1'b0;
        busy_n = busy_sig ? 1 : 0;
        lat = 0;
        while (lat < 40 && !done_sig) begin
            @(posedge CLK);
            #1;
            lat++;
            bin_data = 20'($urandom);
            if (busy_sig) busy_n++;
        end
        chk({tag, " latency"}, lat, 21);
        chk({tag, " busy_cycles"}, busy_n, 21);
        chk({tag, " bcd"}, {8'h0, bcd_sig}, {8'h0, ref_bcd(32'(v))});
        chk({tag, " ovf"}, {31'h0, ovf_sig}, {31'h0, (32'(v) > 999_999)});
        chk({tag, " busy_at_done"}, {31'h0, busy_sig}, 32'h0);
        @(posedge CLK);
        #1;
        chk({tag, " done_width"}, {31'h0, done_sig}, 32'h0);
    endtask

    initial begin
        int dones;
        int idx;
        logic [23:0] got;
        logic [19:0] q[$];
        logic [19:0] r;

        total = 0;
        bad = 0;
        RSTn = 1'b0;
        start_sig = 1'b0;
        bin_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset bcd", {8'h0, bcd_sig}, 32'h0);
        chk("reset done", {31'h0, done_sig}, 32'h0);
        chk("reset busy", {31'h0, busy_sig}, 32'h0);
        chk("reset ovf", {31'h0, ovf_sig}, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;

        convert(20'd0, "zero");
        convert(20'd123_456, "v123456");
        convert(20'd999_999, "v999999");
        convert(20'd1_000_000, "v1000000");
        convert(20'hFFFFF, "vFFFFF");
        convert(20'd9, "v9");

        // Start request during a conversion must be ignored, not queued.
        @(negedge CLK);
        start_sig = 1'b1;
        bin_data = 20'd42;
        @(posedge CLK);
        #1;
        start_sig = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            bin_data = 20'($urandom);
        end
        start_sig = 1'b1;
        bin_data = 20'd777;
        dones = 0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            start_sig = 1'b0;
            bin_data = 20'($urandom);
            if (done_sig) begin
                dones++;
                got = bcd_sig;
            end
        end
        chk("ignore done_count", dones, 1);
        chk("ignore bcd", {8'h0, got}, 32'h42);

        // Continuous start: acceptance every 22 clocks on the value present at that edge.
        @(negedge CLK);
        start_sig = 1'b1;
        bin_data = 20'd0;
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            if (i % 22 == 0) q.push_back(20'(i < 50 ? i : 49));
            @(posedge CLK);
            #1;
            bin_data = 20'(i + 1 < 50 ? i + 1 : 49);
            if (done_sig) begin
                dones++;
                chk("stream done_phase", i % 22, 21);
                r = (q.size() > 0) ? q.pop_front() : 20'hFFFFF;
                chk("stream bcd", {8'h0, bcd_sig}, {8'h0, ref_bcd(32'(r))});
            end
        end
        start_sig = 1'b0;
        chk("stream done_count", dones, 3);
        repeat (25) @(posedge CLK);

        // Overflow result on display, then reset aborts a conversion mid-way.
        convert(20'd1_000_000, "pre_reset");
        @(negedge CLK);
        start_sig = 1'b1;
        bin_data = 20'd654_321;
        @(posedge CLK);
        #1;
        start_sig = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("abort bcd", {8'h0, bcd_sig}, 32'h0);
        chk("abort ovf", {31'h0, ovf_sig}, 32'h0);
        chk("abort busy", {31'h0, busy_sig}, 32'h0);
        dones = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (done_sig) dones++;
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK);
            #1;
            if (done_sig) dones++;
        end
        chk("abort no_done", dones, 0);
        convert(20'd654_321, "after_reset");

        for (int n = 0; n < 20; n++) begin
            idx = ($urandom_range(0, 3) == 0) ? $urandom_range(999_990, 1_048_575)
                                              : $urandom_range(0, 999_999);
            convert(20'(idx), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
